// File: rtl/snn_fp_pkg.sv
// Shared IEEE-754 single-precision field constants and FSM encoding
// for the synaptic potential accumulator.
package snn_fp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_W    = 23;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] FP_ZERO       = 32'h00000000;
  localparam logic [30:0] FP_MAX_FINITE = 31'h7F7FFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ADD   = 2'd2,
    NORM  = 2'd3
  } acc_state_t;

  // 24-bit significand with hidden bit; exponent 0 (zero/denormal) flushes to 0.
  function automatic logic [23:0] full_man(input logic [31:0] f);
    return (f[EXP_MSB:EXP_LSB] == 8'd0) ? 24'd0 : {1'b1, f[MAN_W-1:0]};
  endfunction

endpackage

// File: rtl/fp_lzc24.sv
// Combinational leading-zero counter over a 24-bit significand.
// An all-zero input reports 24.
module fp_lzc24 (
  input  logic [23:0] din,
  output logic [4:0]  lz
);

  always_comb begin
    lz = 5'd24;
    // Ascending scan: the highest set bit is the last to overwrite.
    for (int i = 0; i < 24; i++) begin
      if (din[i]) lz = 5'(23 - i);
    end
  end

endmodule

// File: rtl/potential_accumulator.sv
// Sums a stream of single-precision synaptic weights per timestep with a
// 4-cycle float add, then hands total and event count to the potential adder.
//
// state | meaning
// IDLE  | waiting for a weight or a timestep commit
// ALIGN | order acc/operand by magnitude, shift smaller significand
// ADD   | add or subtract aligned significands
// NORM  | normalise, round-free pack, write acc
module potential_accumulator
  import snn_fp_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [31:0]      weight_in,
  input  logic             weight_valid,
  output logic             weight_ready,
  input  logic             time_step,
  output logic [31:0]      acc_out,
  output logic [CNT_W-1:0] acc_count,
  output logic             acc_valid
);

  localparam logic signed [9:0] EXP_SAT = 10'(EXP_MAX);

  acc_state_t state, state_nxt;

  logic [31:0]      acc;
  logic [31:0]      opnd;
  logic [CNT_W-1:0] count;
  logic             pending;
  logic             skip;

  logic             a_sign;
  logic [7:0]       a_exp;
  logic [23:0]      a_man;
  logic [23:0]      b_man;
  logic             sub;
  logic [24:0]      sum;

  logic             accept;
  logic             commit;

  assign weight_ready = !RESET && (state == IDLE) && !pending && !time_step;
  assign accept       = weight_valid && weight_ready;
  assign commit       = (state == IDLE) && (time_step || pending);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ALIGN;
      ALIGN:   state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALIGN: pick the larger-magnitude operand as A, shift B right by the exponent gap
  logic [7:0]  x_exp, y_exp, al_exp, bl_exp, diff;
  logic [23:0] x_man, y_man, al_man, bl_man, al_bman;
  logic        y_big, al_sign;

  always_comb begin
    x_exp   = (acc[EXP_MSB:EXP_LSB] == 8'd0)  ? 8'd0 : acc[EXP_MSB:EXP_LSB];
    y_exp   = (opnd[EXP_MSB:EXP_LSB] == 8'd0) ? 8'd0 : opnd[EXP_MSB:EXP_LSB];
    x_man   = full_man(acc);
    y_man   = full_man(opnd);
    y_big   = {y_exp, y_man} > {x_exp, x_man};
    al_sign = y_big ? opnd[SIGN_BIT] : acc[SIGN_BIT];
    al_exp  = y_big ? y_exp : x_exp;
    al_man  = y_big ? y_man : x_man;
    bl_exp  = y_big ? x_exp : y_exp;
    bl_man  = y_big ? x_man : y_man;
    diff    = al_exp - bl_exp;
    al_bman = (diff >= 8'd25) ? 24'd0 : (bl_man >> diff);
  end

  // NORM: carry shifts right, otherwise a one-cycle left normalise via LZC
  logic [4:0]        lz;
  logic signed [9:0] exp_n;
  logic [23:0]       man_n;
  logic [31:0]       norm_res;

  fp_lzc24 u_lzc (
    .din (sum[23:0]),
    .lz  (lz)
  );

  always_comb begin
    exp_n    = '0;
    man_n    = '0;
    norm_res = FP_ZERO;
    if (sum[24]) begin
      man_n = sum[24:1];
      exp_n = $signed({2'b00, a_exp}) + 10'sd1;
    end else begin
      man_n = sum[23:0] << lz;
      exp_n = $signed({2'b00, a_exp}) - $signed({5'b00000, lz});
    end
    if (sum == 25'd0 || exp_n <= 10'sd0)
      norm_res = FP_ZERO;
    else if (exp_n >= EXP_SAT)
      norm_res = {a_sign, FP_MAX_FINITE};
    else
      norm_res = {a_sign, exp_n[7:0], man_n[MAN_W-1:0]};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      acc       <= FP_ZERO;
      acc_out   <= FP_ZERO;
      acc_count <= '0;
      acc_valid <= 1'b0;
      count     <= '0;
      pending   <= 1'b0;
      opnd      <= FP_ZERO;
      skip      <= 1'b0;
      a_sign    <= 1'b0;
      a_exp     <= '0;
      a_man     <= '0;
      b_man     <= '0;
      sub       <= 1'b0;
      sum       <= '0;
    end else begin
      acc_valid <= commit;
      if (commit) begin
        acc_out   <= acc;
        acc_count <= count;
        acc       <= FP_ZERO;
        count     <= '0;
        pending   <= 1'b0;
      end else begin
        if (state != IDLE && time_step) pending <= 1'b1;
        if (accept) begin
          opnd <= weight_in;
          // Inf/NaN still count as events but never reach acc
          skip <= (weight_in[EXP_MSB:EXP_LSB] == 8'(EXP_MAX));
          if (count != {CNT_W{1'b1}}) count <= count + 1'b1;
        end
      end

      if (state == ALIGN) begin
        a_sign <= al_sign;
        a_exp  <= al_exp;
        a_man  <= al_man;
        b_man  <= al_bman;
        sub    <= acc[SIGN_BIT] ^ opnd[SIGN_BIT];
      end

      if (state == ADD) begin
        if (sub) sum <= {1'b0, a_man} - {1'b0, b_man};
        else     sum <= {1'b0, a_man} + {1'b0, b_man};
      end

      if (state == NORM && !skip) acc <= norm_res;
    end
  end

endmodule

// File: tb/tb_potential_accumulator.sv
// Scoreboard bench for potential_accumulator: expected commits are queued at
// each timestep pulse and checked by a monitor whenever acc_valid fires.
module tb_potential_accumulator;

  logic        CLK;
  logic        RESET;
  logic [31:0] weight_in;
  logic        weight_valid;
  logic        weight_ready;
  logic        time_step;
  logic [31:0] acc_out;
  logic [15:0] acc_count;
  logic        acc_valid;

  int total = 0;
  int bad   = 0;

  logic [47:0] exp_q[$];
  bit          prev_valid = 1'b0;

  potential_accumulator #(.CNT_W(16)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .weight_in    (weight_in),
    .weight_valid (weight_valid),
    .weight_ready (weight_ready),
    .time_step    (time_step),
    .acc_out      (acc_out),
    .acc_count    (acc_count),
    .acc_valid    (acc_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET) begin
      prev_valid = 1'b0;
    end else begin
      if (acc_valid) begin
        logic [47:0] e;
        check("valid_single_cycle", {31'b0, prev_valid}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_commit actual=%h required=none", acc_out);
        end else begin
          e = exp_q.pop_front();
          check("acc_out", acc_out, e[31:0]);
          check("acc_count", {16'b0, acc_count}, {16'b0, e[47:32]});
        end
      end
      prev_valid = acc_valid;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  // (or after the ready-low window when chk is set).
  task automatic send(input logic [31:0] w, input bit chk);
    int n = 0;
    weight_in    = w;
    weight_valid = 1'b1;
    #1;
    while (!weight_ready && n < 50) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (!weight_ready) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout actual=ready_low required=ready_high");
      weight_valid = 1'b0;
      @(negedge CLK);
      return;
    end
    @(posedge CLK);
    @(negedge CLK);
    weight_valid = 1'b0;
    if (chk) begin
      for (int i = 0; i < 3; i++) begin
        check("ready_low_busy", {31'b0, weight_ready}, 32'd0);
        @(negedge CLK);
      end
      check("ready_back", {31'b0, weight_ready}, 32'd1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    #1;
    while (!weight_ready && n < 50) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("idle_reached", {31'b0, weight_ready}, 32'd1);
  endtask

  task automatic pulse_ts(input logic [31:0] eo, input logic [15:0] ec);
    exp_q.push_back({ec, eo});
    time_step = 1'b1;
    @(negedge CLK);
    time_step = 1'b0;
  endtask

  initial begin
    int n;
    RESET        = 1'b1;
    weight_in    = 32'h0;
    weight_valid = 1'b0;
    time_step    = 1'b0;
    #3;
    check("rst_acc_out",   acc_out, 32'h0);
    check("rst_acc_count", {16'b0, acc_count}, 32'h0);
    check("rst_acc_valid", {31'b0, acc_valid}, 32'h0);
    check("rst_ready",     {31'b0, weight_ready}, 32'h0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    // 5.0 + 4.0 = 9.0
    send(32'h40A00000, 1'b1);
    send(32'h40800000, 1'b1);
    wait_idle();
    pulse_ts(32'h41100000, 16'd2);

    // 1.5 + -1.5 = +0
    send(32'h3FC00000, 1'b0);
    send(32'hBFC00000, 1'b0);
    wait_idle();
    pulse_ts(32'h00000000, 16'd2);

    // 2^-24 is truncated away against 1.0
    send(32'h3F800000, 1'b0);
    send(32'h33800000, 1'b0);
    wait_idle();
    pulse_ts(32'h3F800000, 16'd2);

    // overflow saturates to max finite
    send(32'h7F7FFFFF, 1'b0);
    send(32'h7F7FFFFF, 1'b0);
    wait_idle();
    pulse_ts(32'h7F7FFFFF, 16'd2);

    // timestep and weight together: timestep wins, weight held by source
    send(32'h3F800000, 1'b0);
    wait_idle();
    exp_q.push_back({16'd1, 32'h3F800000});
    time_step    = 1'b1;
    weight_in    = 32'h40A00000;
    weight_valid = 1'b1;
    #1;
    check("ready_low_on_ts", {31'b0, weight_ready}, 32'd0);
    @(negedge CLK);
    time_step = 1'b0;
    send(32'h40A00000, 1'b0);
    wait_idle();
    pulse_ts(32'h40A00000, 16'd1);

    // timestep during ADD commits right after NORM, including that weight
    wait_idle();
    send(32'h40A00000, 1'b0);
    wait_idle();
    send(32'h40800000, 1'b0);
    @(negedge CLK);
    exp_q.push_back({16'd2, 32'h41100000});
    time_step = 1'b1;
    @(negedge CLK);
    time_step = 1'b0;
    @(negedge CLK);
    #1;
    check("ready_low_pending", {31'b0, weight_ready}, 32'd0);
    check("no_early_commit",   {31'b0, acc_valid}, 32'd0);
    @(negedge CLK);
    check("commit_after_norm", {31'b0, acc_valid}, 32'd1);

    // reset mid-NORM abandons the add
    wait_idle();
    send(32'h40A00000, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("midrst_acc_out",   acc_out, 32'h0);
    check("midrst_acc_count", {16'b0, acc_count}, 32'h0);
    check("midrst_acc_valid", {31'b0, acc_valid}, 32'h0);
    check("midrst_ready",     {31'b0, weight_ready}, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    send(32'h40800000, 1'b0);
    wait_idle();
    pulse_ts(32'h40800000, 16'd1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/potential_accumulator.md
Name: potential_accumulator

Overview:
- Upstream stage of the neuron potential adder; produces its 32-bit accumulator input, the summed synaptic weight for one timestep.
- Accepts a stream of IEEE-754 single-precision synaptic weights through a valid/ready handshake.
- Sums them in a multi-cycle floating-point add FSM.
- On each timestep pulse, presents the total (plus an event count) to the adder and clears the running sum.

Parameters:
- CNT_W, 16, width of the per-timestep accepted-weight counter (saturating).

Ports:
- CLK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- weight_in  in  32  IEEE-754 single-precision synaptic weight
- weight_valid  in  1  weight_in is valid
- weight_ready  out  1  block can accept a weight this cycle
- time_step  in  1  one-cycle pulse marking end of timestep
- acc_out  out  32  IEEE-754 summed weight of the last completed timestep; feeds the adder's weight input
- acc_count  out  CNT_W  number of weights accepted in the last completed timestep
- acc_valid  out  1  one-cycle pulse when acc_out/acc_count update

Behaviour:
- Interface: one clock CLK; reset RESET is asynchronous and active-high.
- Reset, asynchronous and taking effect immediately:
  - acc=0x00000000, acc_out=0x00000000, acc_count=0, acc_valid=0, count=0, pending=0, state=IDLE.
  - weight_ready=0 while RESET is high.
  - Reset mid-operation abandons the in-flight add; the weight is lost.
- States: IDLE -> ALIGN -> ADD -> NORM -> IDLE.
- weight_ready = (state==IDLE) && !pending && !time_step, purely combinational.
- Handshake: transfer happens on a rising edge with weight_valid && weight_ready.
  - The operand is registered and the FSM goes to ALIGN.
  - count increments, saturating at all-ones.
- ALIGN:
  - Operands with exponent 0 are treated as zero (denormals flushed).
  - Order operands by magnitude (exponent, then mantissa) so A >= B.
  - Right-shift B's 24-bit mantissa (hidden bit included) by the exponent difference; a difference >= 25 gives B = 0.
  - Shifted-out bits are discarded (truncation, no rounding).
- ADD: equal signs add the mantissas into 25 bits; unequal signs compute A-B. Result sign is A's sign.
- NORM:
  - On carry, shift right 1 and increment the exponent.
  - Otherwise, left-shift by leading-zero count in a single cycle and decrement the exponent by the same amount.
  - Zero mantissa, or exponent underflow <= 0, gives +0 (0x00000000).
  - Exponent >= 255 saturates to signed max finite (0x7F7FFFFF or 0xFF7FFFFF).
  - acc is written at the end of NORM, then the FSM returns to IDLE.
- Inputs with exponent 255 (Inf/NaN) are accepted and counted, but acc is unchanged.
- Latency and throughput:
  - Accept at edge N; acc holds the new value after edge N+3.
  - weight_ready reasserts in the cycle after edge N+3.
  - Throughput is 1 weight per 4 cycles.
- time_step:
  - Sets pending when seen outside IDLE.
  - Commit happens in IDLE when (time_step || pending): acc_out<=acc, acc_count<=count, acc<=0, count<=0, pending<=0, acc_valid<=1 for one cycle.
  - A pulse arriving during ALIGN/ADD/NORM commits on the first IDLE cycle, after that weight is included.
- Simultaneous time_step and weight_valid in IDLE: the timestep wins. The weight is not accepted and must be held by the source; it lands in the next timestep's sum.
- A second time_step while pending is already set is absorbed; one commit results.
- Between commits, acc_out and acc_count are held.

Decomposition:
- Package snn_fp_pkg holds:
  - field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_W=23, EXP_MAX=255
  - FP_ZERO=32'h00000000 and FP_MAX_FINITE=31'h7F7FFFFF
  - FSM state encoding (IDLE/ALIGN/ADD/NORM)
- Sub-module fp_lzc24: a combinational 24-bit leading-zero counter with 5-bit output, used in NORM.

Test Plan:
- Reset then 5.0 (0x40A00000) and 4.0 (0x40800000), then time_step -> acc_out=0x41100000 (9.0), acc_count=2, acc_valid high exactly 1 cycle; weight_ready low for 3 cycles after each accept.
- 1.5 (0x3FC00000) then -1.5 (0xBFC00000), time_step -> acc_out=0x00000000, acc_count=2.
- 1.0 (0x3F800000) then 2^-24 (0x33800000) -> acc_out=0x3F800000 (truncation). Also 0x7F7FFFFF twice -> acc_out=0x7F7FFFFF (saturation).
- time_step coincident with weight_valid (weight 0x40A00000) in IDLE:
  - weight_ready=0, commit of the previous sum, weight held by the source.
  - The next time_step gives acc_out=0x40A00000, acc_count=1.
- time_step pulsed during ADD of 0x40800000 onto acc=0x40A00000 -> commit one cycle after NORM, acc_out=0x41100000.
- RESET asserted mid-NORM:
  - All outputs are 0 immediately and weight_ready=0.
  - After release, a single weight of 0x40800000 plus time_step gives acc_out=0x40800000.
